br_resolve_unit: RTL

Parametrised, pipelined branch-resolution unit for the RV32I core's execute stage. It evaluates the RISC-V branch condition on two XLEN-wide operands and compares the result with the fetch-stage prediction. It computes the redirect PC and returns the result through a valid/ready pipeline of configurable depth. It also supports pipeline flush and keeps saturating branch and mispredict counters for the CSR/performance block.

---
 rtl/br_resolve_if.sv | 35 +++
 rtl/br_resolve_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_if.sv
// Request/result bundle between the execute stage and the branch-resolution unit.
// master = issuing side (execute/consumer), slave = br_resolve_unit.
interface br_resolve_if #(
    parameter int XLEN = 32
);
    // Request side
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] ina;
    logic [XLEN-1:0] inb;
    logic [2:0]      br_type;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
    logic [3:0]      in_tag;

    // Result side
    logic            out_valid;
    logic            out_ready;
    logic            br_taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            illegal;
    logic [3:0]      out_tag;

    modport master (
        output in_valid, ina, inb, br_type, pc, imm, pred_taken, in_tag, out_ready,
        input  in_ready, out_valid, br_taken, mispredict, redirect_pc, illegal, out_tag
    );

    modport slave (
        input  in_valid, ina, inb, br_type, pc, imm, pred_taken, in_tag, out_ready,
        output in_ready, out_valid, br_taken, mispredict, redirect_pc, illegal, out_tag
    );
endinterface

// File: rtl/br_resolve_unit.sv
// Branch-resolution unit: evaluates the RV32I branch condition, compares it with
// the fetch prediction, forms the redirect PC and returns the result through a
// 1- or 2-deep valid/ready pipeline. Keeps saturating branch/mispredict counters.
module br_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int LAT   = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             clr_cnt,
    br_resolve_if.slave      bus,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    // Branch condition for a funct3 encoding; reserved encodings resolve not-taken.
    function automatic logic eval_cond(input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b,
                                       input logic [2:0]      f3);
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic                   r;
        a_s = signed'(a);
        b_s = signed'(b);
        case (f3)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b100:  r = (a_s <  b_s);
            3'b101:  r = (a_s >= b_s);
            3'b110:  r = (a <  b);
            3'b111:  r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // funct3 010/011 are not branch encodings.
    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: combinational evaluation of the incoming request
    // ------------------------------------------------------------------
    logic            taken_c;
    logic            ill_c;
    logic [XLEN-1:0] tgt_c;
    logic [XLEN-1:0] seq_c;
    logic            s1_leave;
    logic            acc;

    assign taken_c = eval_cond(bus.ina, bus.inb, bus.br_type);
    assign ill_c   = is_illegal(bus.br_type);
    // Both sums wrap silently at XLEN bits.
    assign tgt_c   = bus.pc + bus.imm;
    assign seq_c   = bus.pc + XLEN'(4);

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic            s1_vld_q;
    logic            s1_vld_d;
    logic            s1_taken_q;
    logic            s1_mp_q;
    logic            s1_ill_q;
    logic [XLEN-1:0] s1_tgt_q;
    logic [XLEN-1:0] s1_seq_q;
    logic [3:0]      s1_tag_q;

    // S1 can take a new request when empty or when its occupant moves on.
    assign bus.in_ready = !s1_vld_q || s1_leave;
    assign acc          = bus.in_valid && bus.in_ready && !flush;

    // S1 occupancy: flush empties it, otherwise it refills whenever it is free to.
    always_comb begin
        s1_vld_d = s1_vld_q;
        if (flush) begin
            s1_vld_d = 1'b0;
        end else if (bus.in_ready) begin
            s1_vld_d = bus.in_valid;
        end
    end

    // S1 valid and payload; payload only loads on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_taken_q <= 1'b0;
            s1_mp_q    <= 1'b0;
            s1_ill_q   <= 1'b0;
            s1_tgt_q   <= '0;
            s1_seq_q   <= '0;
            s1_tag_q   <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            if (acc) begin
                s1_taken_q <= taken_c;
                s1_mp_q    <= taken_c ^ bus.pred_taken;
                s1_ill_q   <= ill_c;
                s1_tgt_q   <= tgt_c;
                s1_seq_q   <= seq_c;
                s1_tag_q   <= bus.in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 register (LAT=2) or direct S1 outputs (LAT=1)
    // ------------------------------------------------------------------
    generate
        if (LAT == 2) begin : g_lat2
            logic            s2_vld_q;
            logic            s2_taken_q;
            logic            s2_mp_q;
            logic            s2_ill_q;
            logic [XLEN-1:0] s2_rpc_q;
            logic [3:0]      s2_tag_q;
            logic            s2_load;

            // S1 moves into S2 whenever S2 is empty or its result is being taken.
            assign s1_leave = !s2_vld_q || bus.out_ready;
            assign s2_load  = s1_vld_q && s1_leave && !flush;

            // S2 holds the presented result; it only changes when S2 advances.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_vld_q   <= 1'b0;
                    s2_taken_q <= 1'b0;
                    s2_mp_q    <= 1'b0;
                    s2_ill_q   <= 1'b0;
                    s2_rpc_q   <= '0;
                    s2_tag_q   <= '0;
                end else begin
                    if (flush) begin
                        s2_vld_q <= 1'b0;
                    end else if (s1_leave) begin
                        s2_vld_q <= s1_vld_q;
                    end
                    if (s2_load) begin
                        s2_taken_q <= s1_taken_q;
                        s2_mp_q    <= s1_mp_q;
                        s2_ill_q   <= s1_ill_q;
                        s2_rpc_q   <= s1_taken_q ? s1_tgt_q : s1_seq_q;
                        s2_tag_q   <= s1_tag_q;
                    end
                end
            end

            assign bus.out_valid   = s2_vld_q;
            assign bus.br_taken    = s2_taken_q;
            assign bus.mispredict  = s2_mp_q;
            assign bus.illegal     = s2_ill_q;
            assign bus.redirect_pc = s2_rpc_q;
            assign bus.out_tag     = s2_tag_q;
        end else begin : g_lat1
            assign s1_leave        = bus.out_ready;
            assign bus.out_valid   = s1_vld_q;
            assign bus.br_taken    = s1_taken_q;
            assign bus.mispredict  = s1_mp_q;
            assign bus.illegal     = s1_ill_q;
            assign bus.redirect_pc = s1_taken_q ? s1_tgt_q : s1_seq_q;
            assign bus.out_tag     = s1_tag_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic             done;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q;
    logic [CNT_W-1:0] mp_cnt_d;

    // A result presented during flush is discarded, so it does not count.
    assign done = bus.out_valid && bus.out_ready && !flush;

    // Counter next state: clear wins over a same-cycle completion.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (clr_cnt) begin
            br_cnt_d = '0;
            mp_cnt_d = '0;
        end else if (done) begin
            br_cnt_d = sat_inc(br_cnt_q);
            if (bus.mispredict) begin
                mp_cnt_d = sat_inc(mp_cnt_q);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_cnt = br_cnt_q;
    assign mp_cnt = mp_cnt_q;

endmodule
